// File: rtl/arbitro_memoria_if.sv
// Bus bundle between two requesters, the arbiter and a shared single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface arbitro_memoria_if;
    logic        m0_req;
    logic        m0_wr;
    logic [63:0] m0_addr;
    logic [63:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [63:0] m0_rdata;

    logic        m1_req;
    logic        m1_wr;
    logic [63:0] m1_addr;
    logic [63:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [63:0] m1_rdata;

    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic [63:0] mem_rdata;
    logic        busy;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_addr, mem_wdata, mem_wr, busy
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter giving two requesters (fetch / load-store) access to one
// single-port memory with fixed read latency RD_LAT (1..15).
module arbitro_memoria #(
    parameter int RD_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    arbitro_memoria_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_wr;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata0;
    logic [63:0] r_rdata1;
    logic [3:0]  r_cnt;
    logic        w_any_req;
    logic        w_winner;

    // On a tie the requester not served last wins.
    always_comb begin
        w_any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) w_winner = ~r_last_owner;
        else                          w_winner = bus.m1_req;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next = ACCESS;
            ACCESS:  w_next = r_wr ? IDLE : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_addr/r_wdata double as the memory bus, so they hold outside a transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_wr         <= w_winner ? bus.m1_wr    : bus.m0_wr;
                        r_addr       <= w_winner ? bus.m1_addr  : bus.m0_addr;
                        r_wdata      <= w_winner ? bus.m1_wdata : bus.m0_wdata;
                    end
                end
                ACCESS: if (!r_wr) r_cnt <= LAT_LOAD;
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (r_owner) begin
                        r_rdata1 <= bus.mem_rdata;
                    end else begin
                        r_rdata0 <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.m0_gnt    = (r_state == ACCESS) && !r_owner;
        bus.m1_gnt    = (r_state == ACCESS) &&  r_owner;
        bus.m0_rvalid = (r_state == RESP)   && !r_owner;
        bus.m1_rvalid = (r_state == RESP)   &&  r_owner;
        bus.m0_rdata  = r_rdata0;
        bus.m1_rdata  = r_rdata1;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_wr    = (r_state == ACCESS) && r_wr;
        bus.busy      = (r_state != IDLE);
    end
endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: memory read latency, in cycles from the address cycle to the cycle mem_rdata is valid; legal range 1-15.
REQ-002 SHALL use one clock, clk, and a synchronous, active-high reset, reset; all state SHALL change only on the rising edge of clk.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 m0_req, m0_wr  input  1 each  requester 0 (instruction fetch) request; write when 1, read when 0.
REQ-006 m0_addr, m0_wdata  input  64 each  requester 0 address and write data.
REQ-007 m0_gnt, m0_rvalid  output  1 each  requester 0 accept pulse and read-data-valid pulse.
REQ-008 m0_rdata  output  64  requester 0 read data.
REQ-009 m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions and widths as the m0_ ports, for requester 1 (load/store path).
REQ-010 mem_addr, mem_wdata  output  64 each  address and write data to the shared single-port memory.
REQ-011 mem_wr  output  1  memory write strobe.
REQ-012 mem_rdata  input  64  memory read data.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, ACCESS, WAIT and RESP.
REQ-015 In IDLE with at least one req high, SHALL select an owner, register its addr, wdata and wr, and move to ACCESS on the next edge.
REQ-016 With only one req high, that requester SHALL win.
REQ-017 With both reqs high, the requester not served most recently SHALL win (round robin via a last_owner register updated at each selection).
REQ-018 In ACCESS, SHALL drive mem_addr and mem_wdata from the registered values and assert the owner's gnt for exactly one cycle.
REQ-019 In ACCESS for a write, SHALL assert mem_wr for that cycle only, then return to IDLE.
REQ-020 In ACCESS for a read, SHALL move to WAIT and load a latency counter with RD_LAT-1.
REQ-021 In WAIT, SHALL decrement the counter, holding mem_addr.
REQ-022 In WAIT, when the counter reads 0 (exactly RD_LAT cycles after the ACCESS cycle), SHALL capture mem_rdata into the owner's rdata register and move to RESP.
REQ-023 In RESP, SHALL assert the owner's rvalid for exactly one cycle, then return to IDLE.
REQ-024 Latency: write, req sampled in cycle T gives gnt and mem_wr in T+1 and IDLE in T+2.
REQ-025 Latency: read, req sampled in cycle T gives gnt in T+1 and rvalid in T+2+RD_LAT.
REQ-026 Requesters SHALL hold req, wr, addr and wdata stable until gnt; the arbiter SHALL ignore input changes after selection.
REQ-027 A req dropped before selection SHALL be ignored without error; no gnt SHALL issue for it.
REQ-028 SHALL never assert both gnts, both rvalids, or gnt together with rvalid for the same port in one cycle.
REQ-029 mem_wr SHALL be 0 in every state except ACCESS-write.
REQ-030 mem_addr and mem_wdata SHALL hold their last values outside ACCESS and WAIT.
REQ-031 mx_rdata SHALL hold its value until that port's next read response.
REQ-032 Requests arriving while busy SHALL wait; arbitration SHALL occur only in IDLE.

Reset
REQ-033 On reset, SHALL enter IDLE and drive to 0: all gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wr and busy.
REQ-034 On reset, last_owner SHALL be set to 1, so requester 0 wins the first tie.
REQ-035 Reset in any state SHALL abandon the transaction: no further gnt, rvalid or mem_wr is issued for it, and mem_wr is 0 from the next cycle.
REQ-036 Reset SHALL override all reqs in the same cycle.

Verification
REQ-037 m0 read, addr 0x40, memory holding 0x1122334455667788, RD_LAT=1 -> m0_gnt in T+1; m0_rvalid in T+3 with m0_rdata=0x1122334455667788; busy high T+1..T+3.
REQ-038 m1 write, addr 0x80, wdata 0xDEADBEEF -> mem_wr=1, mem_addr=0x80, mem_wdata=0xDEADBEEF, m1_gnt=1, all in T+1 only; IDLE in T+2.
REQ-039 Both reqs held continuously with reads, right after reset -> grants alternate m0, m1, m0, m1; never two gnts in one cycle.
REQ-040 Reset asserted during WAIT of an m1 read -> no m1_rvalid ever; m1_rdata=0, busy=0 on the cycle after reset.
REQ-041 RD_LAT=3, m0 read -> rvalid exactly 5 cycles after the req-sampled cycle, with data captured from the third cycle after ACCESS.
REQ-042 m1_req raised during an m0 transaction -> m1 selected in the first IDLE cycle after it, gnt one cycle later.
